// File: rtl/ble_tx_crc_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ble_tx_crc_serializer
// Description : BLE transmit byte-to-bit serializer with CRC24 generation.
//               PDU bytes arrive over valid/ready and go out LSB-first, one
//               bit per bit_tick. The 24-bit CRC follows, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module ble_tx_crc_serializer #(
   parameter int PDU_LEN_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [23:0]              crc_init,
   input  logic [PDU_LEN_WIDTH-1:0] pdu_len,
   input  logic                     bit_tick,
   input  logic [7:0]               byte_in,
   input  logic                     byte_in_valid,
   output logic                     byte_in_ready,
   output logic                     bit_out,
   output logic                     bit_out_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     underrun,
   output logic [23:0]              crc_out
);

   // CRC24 feedback taps: x^10+x^9+x^6+x^4+x^3+x+1 (x^24 is the shift-out)
   localparam logic [23:0]              C_CRC_POLY = 24'h00065B;
   localparam logic [PDU_LEN_WIDTH-1:0] C_LEN_ONE  = {{(PDU_LEN_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_CRC  = 2'd2
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic [23:0]              r_lfsr, w_lfsr_nxt;
   logic [PDU_LEN_WIDTH-1:0] r_pdu_len, w_pdu_len_nxt;
   logic [PDU_LEN_WIDTH-1:0] r_bytes_left, w_bytes_left_nxt;
   logic [PDU_LEN_WIDTH-1:0] r_bytes_fetched, w_bytes_fetched_nxt;
   logic [7:0]               r_hold, w_hold_nxt;
   logic                     r_hold_full, w_hold_full_nxt;
   logic [7:0]               r_sreg, w_sreg_nxt;
   logic [3:0]               r_sreg_cnt, w_sreg_cnt_nxt;
   logic [4:0]               r_bit_cnt, w_bit_cnt_nxt;

   logic                     w_ready_nxt;
   logic                     w_bit_out_nxt;
   logic                     w_bit_out_valid_nxt;
   logic                     w_busy_nxt;
   logic                     w_done_nxt;
   logic                     w_underrun_nxt;
   logic [23:0]              w_crc_out_nxt;

   logic                     w_hs;
   logic [7:0]               w_cur_byte;
   logic [3:0]               w_cur_cnt;
   logic                     w_d;
   logic                     w_nb;

   // Next-state, datapath and registered-output computation
   always_comb begin
      w_state_nxt         = r_state;
      w_lfsr_nxt          = r_lfsr;
      w_pdu_len_nxt       = r_pdu_len;
      w_bytes_left_nxt    = r_bytes_left;
      w_bytes_fetched_nxt = r_bytes_fetched;
      w_hold_nxt          = r_hold;
      w_hold_full_nxt     = r_hold_full;
      w_sreg_nxt          = r_sreg;
      w_sreg_cnt_nxt      = r_sreg_cnt;
      w_bit_cnt_nxt       = r_bit_cnt;
      w_bit_out_nxt       = bit_out;
      w_bit_out_valid_nxt = 1'b0;
      w_done_nxt          = 1'b0;
      w_underrun_nxt      = 1'b0;
      w_crc_out_nxt       = crc_out;

      w_hs       = byte_in_valid && byte_in_ready;
      // An empty shift register is refilled from the holding register on the
      // same tick that emits its first bit.
      w_cur_byte = (r_sreg_cnt == 4'd0) ? r_hold : r_sreg;
      w_cur_cnt  = (r_sreg_cnt == 4'd0) ? 4'd8 : r_sreg_cnt;
      w_d        = w_cur_byte[0];
      w_nb       = r_lfsr[23] ^ w_d;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_lfsr_nxt          = crc_init;
               w_pdu_len_nxt       = pdu_len;
               w_bytes_left_nxt    = pdu_len;
               w_bytes_fetched_nxt = '0;
               w_hold_nxt          = 8'd0;
               w_hold_full_nxt     = 1'b0;
               w_sreg_nxt          = 8'd0;
               w_sreg_cnt_nxt      = 4'd0;
               w_bit_cnt_nxt       = 5'd23;
               w_state_nxt         = (pdu_len != '0) ? S_DATA : S_CRC;
            end
         end

         S_DATA: begin
            if (bit_tick) begin
               if ((r_sreg_cnt == 4'd0) && !r_hold_full) begin
                  w_underrun_nxt = 1'b1;
                  w_state_nxt    = S_IDLE;
               end else begin
                  if (r_sreg_cnt == 4'd0) begin
                     w_hold_full_nxt = 1'b0;
                  end
                  w_bit_out_nxt       = w_d;
                  w_bit_out_valid_nxt = 1'b1;
                  w_sreg_nxt          = {1'b0, w_cur_byte[7:1]};
                  w_sreg_cnt_nxt      = w_cur_cnt - 4'd1;
                  w_lfsr_nxt          = {r_lfsr[22:0], 1'b0} ^ ({24{w_nb}} & C_CRC_POLY);
                  if (w_cur_cnt == 4'd1) begin
                     w_bytes_left_nxt = r_bytes_left - C_LEN_ONE;
                     if (r_bytes_left == C_LEN_ONE) begin
                        w_state_nxt   = S_CRC;
                        w_bit_cnt_nxt = 5'd23;
                     end
                  end
               end
            end
            // A new byte landing in the same cycle as a tick-load refills hold
            if (w_hs) begin
               w_hold_nxt          = byte_in;
               w_hold_full_nxt     = 1'b1;
               w_bytes_fetched_nxt = r_bytes_fetched + C_LEN_ONE;
            end
         end

         S_CRC: begin
            if (bit_tick) begin
               w_bit_out_nxt       = r_lfsr[r_bit_cnt];
               w_bit_out_valid_nxt = 1'b1;
               if (r_bit_cnt == 5'd0) begin
                  w_done_nxt    = 1'b1;
                  w_crc_out_nxt = r_lfsr;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt - 5'd1;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_ready_nxt = (w_state_nxt == S_DATA) && !w_hold_full_nxt &&
                    (w_bytes_fetched_nxt < w_pdu_len_nxt);
   end

   // State, datapath and output registers; reset aborts any packet at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_lfsr          <= 24'd0;
         r_pdu_len       <= '0;
         r_bytes_left    <= '0;
         r_bytes_fetched <= '0;
         r_hold          <= 8'd0;
         r_hold_full     <= 1'b0;
         r_sreg          <= 8'd0;
         r_sreg_cnt      <= 4'd0;
         r_bit_cnt       <= 5'd0;
         byte_in_ready   <= 1'b0;
         bit_out         <= 1'b0;
         bit_out_valid   <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         underrun        <= 1'b0;
         crc_out         <= 24'd0;
      end else begin
         r_state         <= w_state_nxt;
         r_lfsr          <= w_lfsr_nxt;
         r_pdu_len       <= w_pdu_len_nxt;
         r_bytes_left    <= w_bytes_left_nxt;
         r_bytes_fetched <= w_bytes_fetched_nxt;
         r_hold          <= w_hold_nxt;
         r_hold_full     <= w_hold_full_nxt;
         r_sreg          <= w_sreg_nxt;
         r_sreg_cnt      <= w_sreg_cnt_nxt;
         r_bit_cnt       <= w_bit_cnt_nxt;
         byte_in_ready   <= w_ready_nxt;
         bit_out         <= w_bit_out_nxt;
         bit_out_valid   <= w_bit_out_valid_nxt;
         busy            <= w_busy_nxt;
         done            <= w_done_nxt;
         underrun        <= w_underrun_nxt;
         crc_out         <= w_crc_out_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ble_tx_crc_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ble_tx_crc_serializer
// Description : Self-checking bench for ble_tx_crc_serializer. A table of
//               packet scenarios is run against a CRC24 reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ble_tx_crc_serializer;

   localparam logic [23:0] C_POLY = 24'h00065B;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] crc_init;
   logic [7:0]  pdu_len;
   logic        bit_tick;
   logic [7:0]  byte_in;
   logic        byte_in_valid;
   logic        byte_in_ready;
   logic        bit_out;
   logic        bit_out_valid;
   logic        busy;
   logic        done;
   logic        underrun;
   logic [23:0] crc_out;

   always #5 clk = ~clk;

   ble_tx_crc_serializer #(.PDU_LEN_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .crc_init      (crc_init),
      .pdu_len       (pdu_len),
      .bit_tick      (bit_tick),
      .byte_in       (byte_in),
      .byte_in_valid (byte_in_valid),
      .byte_in_ready (byte_in_ready),
      .bit_out       (bit_out),
      .bit_out_valid (bit_out_valid),
      .busy          (busy),
      .done          (done),
      .underrun      (underrun),
      .crc_out       (crc_out)
   );

   // kind: 0 = random bytes, 1 = all 0x00, 2 = all 0xA1
   typedef struct {
      logic [23:0] init;
      int          len;
      int          period;
      int          kind;
      int          withhold;
      int          rst_after;
      bit          poke;
      int          exp_nbits;
      int          exp_done;
      int          exp_ur;
      bit          use_crc;
      logic [23:0] exp_crc;
   } vec_t;

   vec_t vecs [9];

   int   n_checks = 0;
   int   n_fail   = 0;

   logic got_bits [$];
   int   n_done, n_underrun, tick_seen, ur_tick, done_nbits;
   logic done_valid, done_busy, ur_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Textbook MSB-first CRC24 step on one data bit
   function automatic logic [23:0] crc_bit(input logic [23:0] c, input logic d);
      logic [24:0] wide;
      wide = {c, 1'b0};
      if (wide[24] ^ d) wide[23:0] = wide[23:0] ^ C_POLY;
      return wide[23:0];
   endfunction

   // Output observer, sampled just after each rising edge
   always @(posedge clk) begin
      #1;
      if (bit_tick) tick_seen++;
      if (bit_out_valid) got_bits.push_back(bit_out);
      if (done) begin
         n_done++;
         done_nbits = got_bits.size();
         done_valid = bit_out_valid;
         done_busy  = busy;
      end
      if (underrun) begin
         n_underrun++;
         ur_tick = tick_seen;
         ur_busy = busy;
      end
   end

   task automatic run_vec(input int vi, input vec_t v);
      logic [7:0]  bytes [256];
      logic        exp_q [$];
      logic [23:0] crc;
      int          idx, cyc, nb;
      bit          acc, ended, did_rst;

      for (int i = 0; i < v.len; i++) begin
         case (v.kind)
            1:       bytes[i] = 8'h00;
            2:       bytes[i] = 8'hA1;
            default: bytes[i] = 8'($urandom);
         endcase
      end
      crc = v.init;
      for (int i = 0; i < v.len; i++) begin
         for (int b = 0; b < 8; b++) begin
            exp_q.push_back(bytes[i][b]);
            crc = crc_bit(crc, bytes[i][b]);
         end
      end
      for (int k = 23; k >= 0; k--) exp_q.push_back(crc[k]);

      got_bits.delete();
      n_done = 0; n_underrun = 0; tick_seen = 0; done_nbits = -1; ur_tick = -1;

      @(negedge clk);
      crc_init = v.init;
      pdu_len  = v.len[7:0];
      start    = 1'b1;
      cyc = 0; idx = 0; acc = 1'b0; ended = 1'b0; did_rst = 1'b0;
      while (!ended) begin
         @(negedge clk);
         cyc++;
         start    = 1'b0;
         crc_init = 24'($urandom);
         pdu_len  = 8'($urandom);
         if (v.poke && cyc == 5) begin
            start    = 1'b1;
            crc_init = ~v.init;
            pdu_len  = 8'(v.len + 3);
         end
         if (n_done != 0 || n_underrun != 0) begin
            ended = 1'b1;
         end else if (v.rst_after > 0 && got_bits.size() >= v.rst_after) begin
            rst = 1'b1;
            #1;
            check($sformatf("v%0d_rst_outputs", vi),
                  32'({bit_out, bit_out_valid, byte_in_ready, busy, done, underrun}), 32'd0);
            check($sformatf("v%0d_rst_crc_out", vi), 32'(crc_out), 32'd0);
            did_rst = 1'b1;
            ended   = 1'b1;
         end else if (cyc > 20000) begin
            check($sformatf("v%0d_timeout", vi), 32'd1, 32'd0);
            ended = 1'b1;
         end
         if (ended) begin
            bit_tick      = 1'b0;
            byte_in_valid = 1'b0;
         end else begin
            if (acc) idx++;
            byte_in_valid = (idx < v.len) && (idx != v.withhold);
            byte_in       = bytes[idx];
            acc           = byte_in_valid && byte_in_ready;
            bit_tick      = (cyc >= 2) && (((cyc - 2) % v.period) == 0);
         end
      end

      // Ticks while idle must produce nothing
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst      = 1'b0;
         bit_tick = ~bit_tick;
      end
      bit_tick = 1'b0;
      @(negedge clk);

      check($sformatf("v%0d_nbits", vi), 32'(got_bits.size()), 32'(v.exp_nbits));
      nb = (got_bits.size() < exp_q.size()) ? got_bits.size() : exp_q.size();
      for (int i = 0; i < nb; i++)
         check($sformatf("v%0d_bit%0d", vi, i), 32'(got_bits[i]), 32'(exp_q[i]));
      check($sformatf("v%0d_done_cnt", vi), 32'(n_done), 32'(v.exp_done));
      check($sformatf("v%0d_underrun_cnt", vi), 32'(n_underrun), 32'(v.exp_ur));
      check($sformatf("v%0d_busy_end", vi), 32'(busy), 32'd0);
      if (n_done != 0) begin
         check($sformatf("v%0d_done_at_last_bit", vi), 32'(done_nbits), 32'(v.exp_nbits));
         check($sformatf("v%0d_done_with_valid", vi), 32'(done_valid), 32'd1);
         check($sformatf("v%0d_busy_at_done", vi), 32'(done_busy), 32'd0);
         check($sformatf("v%0d_crc_out_model", vi), 32'(crc_out), 32'(crc));
         if (v.use_crc) check($sformatf("v%0d_crc_out_const", vi), 32'(crc_out), 32'(v.exp_crc));
      end
      if (n_underrun != 0) begin
         check($sformatf("v%0d_underrun_tick", vi), 32'(ur_tick), 32'(8 * v.withhold + 1));
         check($sformatf("v%0d_busy_at_underrun", vi), 32'(ur_busy), 32'd0);
      end
      if (did_rst) check($sformatf("v%0d_no_done_after_rst", vi), 32'(n_done), 32'd0);
   endtask

   logic a1_bits [8];

   initial begin
      vecs[0] = '{init:24'h555555, len:0,   period:4, kind:0, withhold:-1, rst_after:0,  poke:0,
                  exp_nbits:24,   exp_done:1, exp_ur:0, use_crc:1, exp_crc:24'h555555};
      vecs[1] = '{init:24'h555555, len:1,   period:3, kind:2, withhold:-1, rst_after:0,  poke:0,
                  exp_nbits:32,   exp_done:1, exp_ur:0, use_crc:0, exp_crc:24'h0};
      vecs[2] = '{init:24'h000000, len:4,   period:2, kind:1, withhold:-1, rst_after:0,  poke:0,
                  exp_nbits:56,   exp_done:1, exp_ur:0, use_crc:1, exp_crc:24'h000000};
      vecs[3] = '{init:24'h8E89BE, len:37,  period:1, kind:0, withhold:-1, rst_after:0,  poke:0,
                  exp_nbits:320,  exp_done:1, exp_ur:0, use_crc:0, exp_crc:24'h0};
      vecs[4] = '{init:24'h555555, len:3,   period:2, kind:0, withhold:1,  rst_after:0,  poke:0,
                  exp_nbits:8,    exp_done:0, exp_ur:1, use_crc:0, exp_crc:24'h0};
      vecs[5] = '{init:24'hABCDEF, len:5,   period:1, kind:0, withhold:-1, rst_after:0,  poke:0,
                  exp_nbits:64,   exp_done:1, exp_ur:0, use_crc:0, exp_crc:24'h0};
      vecs[6] = '{init:24'h555555, len:2,   period:4, kind:0, withhold:-1, rst_after:21, poke:0,
                  exp_nbits:21,   exp_done:0, exp_ur:0, use_crc:0, exp_crc:24'h0};
      vecs[7] = '{init:24'h0F1E2D, len:6,   period:2, kind:0, withhold:-1, rst_after:0,  poke:1,
                  exp_nbits:72,   exp_done:1, exp_ur:0, use_crc:0, exp_crc:24'h0};
      vecs[8] = '{init:24'h3C5A96, len:255, period:1, kind:0, withhold:-1, rst_after:0,  poke:0,
                  exp_nbits:2064, exp_done:1, exp_ur:0, use_crc:0, exp_crc:24'h0};
      a1_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; crc_init = 24'd0; pdu_len = 8'd0;
      bit_tick = 1'b0; byte_in = 8'd0; byte_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({bit_out, bit_out_valid, byte_in_ready, busy, done, underrun}), 32'd0);
      check("reset_crc_out", 32'(crc_out), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int vi = 0; vi < 9; vi++) begin
         run_vec(vi, vecs[vi]);
         if (vi == 0 && got_bits.size() >= 24) begin
            for (int i = 0; i < 24; i++)
               check($sformatf("crc_only_alt_bit%0d", i), 32'(got_bits[i]), 32'(i % 2));
         end
         if (vi == 1 && got_bits.size() >= 8) begin
            for (int i = 0; i < 8; i++)
               check($sformatf("a1_order_bit%0d", i), 32'(got_bits[i]), 32'(a1_bits[i]));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ble_tx_crc_serializer.md
# ble_tx_crc_serializer

Byte-to-bit serializer and CRC24 generator for the BLE transmit chain. It sits directly upstream of the whitening (scrambler) stage. The block takes PDU bytes over a valid/ready handshake and emits them LSB-first, one bit per `bit_tick`. It then appends the 24-bit CRC, MSB (position 23) first, so the downstream scrambler can consume `bit_out`/`bit_out_valid` directly as its `data_in`/`data_in_valid`.

## Interface
- `PDU_LEN_WIDTH`, 8, width of the PDU byte-count input (max PDU 255 bytes)
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  single-cycle pulse; latches `crc_init` and `pdu_len`, begins a packet; ignored while `busy`
- `crc_init`  in  24  CRC preset; bit 0 loads LFSR position 0
- `pdu_len`  in  PDU_LEN_WIDTH  number of PDU bytes (header + payload)
- `bit_tick`  in  1  bit-rate strobe; one output bit per tick
- `byte_in`  in  8  PDU byte
- `byte_in_valid`  in  1  `byte_in` valid
- `byte_in_ready`  out  1  block accepts `byte_in` this cycle
- `bit_out`  out  1  serial bit to the scrambler
- `bit_out_valid`  out  1  one-cycle pulse per emitted bit
- `busy`  out  1  packet in progress
- `done`  out  1  one-cycle pulse after the last CRC bit
- `underrun`  out  1  one-cycle pulse; byte not available when needed, packet aborted
- `crc_out`  out  24  final CRC register, stable from `done` until the next `start`

## Operation
- States: IDLE, DATA, CRC.
- **IDLE**
  - `start` → latch `crc_init` into `lfsr[23:0]`, latch `pdu_len` into `bytes_left`, clear the holding and shift buffers.
  - Go to DATA if `pdu_len` ≠ 0, else CRC with `bit_cnt` = 23.
- **Buffering:** one holding register (`hold`, `hold_full`) plus an 8-bit shift register (`sreg`, `sreg_cnt` 0..8).
  - `byte_in_ready` = `busy` && state==DATA && !`hold_full` && `bytes_fetched` < `pdu_len`.
  - Handshake completes when `byte_in_valid` && `byte_in_ready`.
- **DATA**, on `bit_tick`:
  - If `sreg_cnt`==0 and `hold_full`: move `hold`→`sreg`, `sreg_cnt`=8, and emit in the same tick.
  - If `sreg_cnt`==0 and !`hold_full`: pulse `underrun`, go to IDLE, no `done`, no bit emitted.
  - Emit bit `d` = `sreg[0]`, shift right, decrement `sreg_cnt`.
  - After the 8th bit of a byte, decrement `bytes_left`; when it reaches 0, go to CRC with `bit_cnt` = 23.
- **CRC update per data bit:** `nb` = `lfsr[23]` ^ `d`.
  - `lfsr[0]` ← `nb`.
  - `lfsr[i]` ← `lfsr[i-1]` ^ `nb` for i ∈ {1,3,4,6,9,10}.
  - `lfsr[i]` ← `lfsr[i-1]` otherwise.
  - Polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- **CRC**, on `bit_tick`:
  - Emit `lfsr[bit_cnt]` and decrement `bit_cnt`; `lfsr` frozen.
  - After `bit_cnt`==0 is emitted: pulse `done`, go to IDLE; `crc_out` holds `lfsr`.
- `bit_tick` in IDLE is ignored.
- `start` while `busy` is ignored.
- A simultaneous handshake and tick-load in one cycle is legal: the tick consumes the old `hold`, and the new byte fills `hold`.

## Timing
- **Reset values:** `bit_out`=0, `bit_out_valid`=0, `byte_in_ready`=0, `busy`=0, `done`=0, `underrun`=0, `crc_out`=0, state=IDLE, `lfsr`=0.
  - Reset mid-packet aborts immediately; no `done`.
- All outputs are registered.
- `bit_out`/`bit_out_valid` appear the cycle after the `bit_tick` that produced them.
- `busy` rises the cycle after `start`. It falls in the same cycle that `done` or `underrun` pulses.
- `done` coincides with the cycle in which the last `bit_out_valid` pulses.
- `byte_in_ready` may be high on the first cycle after `start`. A byte accepted at least one cycle before the first tick avoids underrun.
- Total bits per packet = 8·`pdu_len` + 24. Exactly that many `bit_out_valid` pulses.
- `bit_tick` spacing of at least 1 cycle is supported (back-to-back ticks legal).

## Test plan
- **CRC-only:** `pdu_len`=0, `crc_init`=0x555555, tick every 4 cycles → 24 bits 0,1,0,1,…,0,1; `done` with last bit; `crc_out`=0x555555.
- **Bit order:** `pdu_len`=1, `byte_in`=0xA1 → first 8 bits 1,0,0,0,0,1,0,1, then 24 CRC bits; `crc_out` matches the software LFSR model.
- **Zero linearity:** `crc_init`=0, 4 bytes 0x00 → 56 zero bits, `crc_out`=0x000000.
- **Throughput:** `pdu_len`=37 random bytes with back-to-back ticks and `byte_in_valid` always high → 320 pulses, no `underrun`, CRC matches model.
- **Underrun:** `pdu_len`=3, withhold the 2nd byte → `underrun` pulse on the 9th tick, `busy` low, no `done`, exactly 8 bits out; a subsequent `start` runs cleanly.
- **Reset and start-while-busy:** assert `rst` mid-CRC → all outputs reset, no `done`; a `start` pulse during DATA is ignored and the packet completes unchanged.
